// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's load/store port.
// Byte-addressable little-endian word array, RV32I load/store sizing and
// extension, one-cycle ack after LATENCY wait cycles.
// Optional feature: define DMEM_MISALIGN_ERR_EN to flag misaligned halfword
// and word accesses (store suppressed, load returns 0, err raised).
module dmem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int WORDS = 2 ** (ADDR_W - 2);
    localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          f3_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                is_wr_q;
    logic                is_rd_q;
    logic                coll_q;

    logic [DATA_W-1:0]   mem [WORDS];

    // Effective access: in IDLE the live inputs (needed when LATENCY=0 and
    // the capture edge is also the commit edge), afterwards the captured copy.
    logic [ADDR_W-1:0]   a_eff;
    logic [2:0]          f_eff;
    logic [DATA_W-1:0]   d_eff;
    logic                op_wr;
    logic                op_rd;
    logic                coll;
    logic                commit;
    logic                is_half;
    logic                is_word;
    logic                misaligned;
    logic [3:0]          be;
    logic [DATA_W-1:0]   wlanes;
    logic [DATA_W-1:0]   word;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [DATA_W-1:0]   load_val;

    // Select live or captured request fields and decode size, lanes and load data
    always_comb begin
        a_eff    = addr_q;
        f_eff    = f3_q;
        d_eff    = wdata_q;
        op_wr    = is_wr_q;
        op_rd    = is_rd_q;
        coll     = coll_q;
        if (state == IDLE) begin
            a_eff = addr;
            f_eff = funct3;
            d_eff = wr_data;
            op_wr = wr;
            op_rd = rd & ~wr;   // write wins a collision
            coll  = wr & rd;
        end

        commit = ((state == IDLE) && (wr | rd) && (LATENCY == 0)) ||
                 ((state == WAIT) && (cnt == 4'd0));

        // funct3[1:0]: 00 byte, 01 half, 10/11 word; funct3[2] = unsigned
        is_half = (f_eff[1:0] == 2'b01);
        is_word = f_eff[1];

        be     = 4'b0001 << a_eff[1:0];
        wlanes = {4{d_eff[7:0]}};
        if (is_word) begin
            be     = 4'b1111;
            wlanes = d_eff;
        end else if (is_half) begin
            be     = a_eff[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{d_eff[15:0]}};
        end

        word     = mem[a_eff[ADDR_W-1:2]];
        byte_sel = word[{a_eff[1:0], 3'b000} +: 8];
        half_sel = a_eff[1] ? word[31:16] : word[15:0];
        if (is_word)
            load_val = word;
        else if (is_half)
            load_val = {{16{half_sel[15] & ~f_eff[2]}}, half_sel};
        else
            load_val = {{24{byte_sel[7] & ~f_eff[2]}}, byte_sel};
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign misaligned = (is_half && a_eff[0]) || (is_word && (a_eff[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Commit store lanes on the edge entering ACK; a reset on that edge drops it
    always_ff @(posedge clk) begin
        if (!reset && commit && op_wr && !misaligned) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[a_eff[ADDR_W-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
        end
    end

    // Request FSM: capture in IDLE, count in WAIT, one-cycle ack with result
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            rd_data <= '0;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            is_rd_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr | rd) begin
                        addr_q  <= addr;
                        f3_q    <= funct3;
                        wdata_q <= wr_data;
                        is_wr_q <= wr;
                        is_rd_q <= rd & ~wr;
                        coll_q  <= wr & rd;
                        busy    <= 1'b1;
                        cnt     <= LAT_M1;
                        state   <= (LATENCY == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= ACK;
                    else
                        cnt <= cnt - 4'd1;
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (commit) begin
                ack <= 1'b1;
                err <= coll | misaligned;
                if (op_rd)
                    rd_data <= misaligned ? '0 : load_val;
            end
        end
    end

endmodule
